// File: rtl/peripheral_dbg_cpu_arbiter.sv
// peripheral_dbg_cpu_arbiter: round-robin arbiter giving debug agents timed, one-at-a-time access to per-core CPU ports
module peripheral_dbg_cpu_arbiter #(
    parameter int X              = 2,
    parameter int Y              = 2,
    parameter int Z              = 2,
    parameter int CORES_PER_TILE = 4,
    parameter int CPU_ADDR_WIDTH = 32,
    parameter int CPU_DATA_WIDTH = 32,
    parameter int REQUESTERS     = 2,
    parameter int TIMEOUT        = 255,
    localparam int NCORES        = X * Y * Z * CORES_PER_TILE,
    localparam int CW            = (NCORES > 1) ? $clog2(NCORES) : 1,
    localparam int RW            = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic                                 cpu_clk_i,
    input  logic                                 cpu_rst_i,
    input  logic [REQUESTERS-1:0]                req_stb_i,
    input  logic [REQUESTERS-1:0]                req_we_i,
    input  logic [REQUESTERS*CW-1:0]             req_core_i,
    input  logic [REQUESTERS*CPU_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [REQUESTERS*CPU_DATA_WIDTH-1:0] req_data_i,
    output logic [REQUESTERS-1:0]                req_ack_o,
    output logic                                 req_err_o,
    output logic [CPU_DATA_WIDTH-1:0]            req_data_o,
    output logic [NCORES-1:0]                    cpu_stb_o,
    output logic [NCORES-1:0]                    cpu_we_o,
    output logic [CPU_ADDR_WIDTH-1:0]            cpu_addr_o,
    output logic [CPU_DATA_WIDTH-1:0]            cpu_data_o,
    input  logic [NCORES*CPU_DATA_WIDTH-1:0]     cpu_data_i,
    input  logic [NCORES-1:0]                    cpu_ack_i
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [CW:0] NC  = (CW + 1)'(NCORES);

    logic [1:0]                state_q, state_d;
    logic [RW-1:0]             grant_q, grant_d, last_q, last_d, sel;
    logic [CW-1:0]             core_q, core_d, sel_core;
    logic                      we_q, we_d, err_q, err_d;
    logic [CPU_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CPU_DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [7:0]                cnt_q, cnt_d;
    int                        idx;

    // round-robin pick: scan downward so the nearest requester after last_q wins
    always_comb begin
        sel = last_q;
        idx = 0;
        for (int i = REQUESTERS; i >= 1; i--) begin
            idx = (int'(last_q) + i) % REQUESTERS;
            if (req_stb_i[idx[RW-1:0]]) sel = idx[RW-1:0];
        end
        sel_core = req_core_i[sel*CW +: CW];
    end

    // FSM next state and latched transaction fields
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        core_d  = core_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (|req_stb_i) begin
                grant_d = sel;
                core_d  = sel_core;
                we_d    = req_we_i[sel];
                addr_d  = req_addr_i[sel*CPU_ADDR_WIDTH +: CPU_ADDR_WIDTH];
                wdata_d = req_data_i[sel*CPU_DATA_WIDTH +: CPU_DATA_WIDTH];
                rdata_d = '0;
                cnt_d   = '0;
                err_d   = {1'b0, sel_core} >= NC;
                state_d = err_d ? DONE : BUSY;
            end
            BUSY: if (cpu_ack_i[core_q]) begin
                rdata_d = cpu_data_i[core_q*CPU_DATA_WIDTH +: CPU_DATA_WIDTH];
                err_d   = 1'b0;
                state_d = DONE;
            end else if (cnt_q == 8'(TIMEOUT)) begin
                rdata_d = '0;
                err_d   = 1'b1;
                state_d = DONE;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            DONE: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers with synchronous reset; last_q starts at the top so requester 0 wins first
    always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= RW'(REQUESTERS - 1);
            core_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            core_q  <= core_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cpu_stb_o  = (state_q == BUSY) ? (NCORES'(1) << core_q) : '0;
    assign cpu_we_o   = (state_q == BUSY && we_q) ? (NCORES'(1) << core_q) : '0;
    assign cpu_addr_o = addr_q;
    assign cpu_data_o = wdata_q;
    assign req_ack_o  = (state_q == DONE) ? (REQUESTERS'(1) << grant_q) : '0;
    assign req_err_o  = (state_q == DONE) && err_q;
    assign req_data_o = (state_q == DONE) ? rdata_q : '0;
endmodule

// File: tb/tb_peripheral_dbg_cpu_arbiter.sv
// tb_peripheral_dbg_cpu_arbiter: directed plus randomized checks of the debug CPU arbiter against a transaction-level model
module tb_peripheral_dbg_cpu_arbiter;
    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_stb, req_we, req_ack;
    logic [9:0]    req_core;
    logic [63:0]   req_addr, req_data;
    logic          req_err;
    logic [31:0]   req_rdata, cpu_stb, cpu_we, cpu_addr, cpu_wdata, cpu_ack;
    logic [1023:0] cpu_rdata;

    logic [1:0]    b_req_stb, b_req_we, b_req_ack;
    logic [7:0]    b_req_core;
    logic [63:0]   b_req_addr, b_req_data;
    logic          b_req_err;
    logic [31:0]   b_req_rdata, b_cpu_addr, b_cpu_wdata;
    logic [8:0]    b_cpu_stb, b_cpu_we, b_cpu_ack;
    logic [287:0]  b_cpu_rdata;

    int checks = 0;
    int failures = 0;
    int tb_last;
    int m_core[2];
    bit m_we[2];
    logic [31:0] m_addr[2], m_data[2];

    always #5 clk = ~clk;

    peripheral_dbg_cpu_arbiter dut (
        .cpu_clk_i(clk), .cpu_rst_i(rst),
        .req_stb_i(req_stb), .req_we_i(req_we), .req_core_i(req_core),
        .req_addr_i(req_addr), .req_data_i(req_data),
        .req_ack_o(req_ack), .req_err_o(req_err), .req_data_o(req_rdata),
        .cpu_stb_o(cpu_stb), .cpu_we_o(cpu_we), .cpu_addr_o(cpu_addr), .cpu_data_o(cpu_wdata),
        .cpu_data_i(cpu_rdata), .cpu_ack_i(cpu_ack)
    );

    peripheral_dbg_cpu_arbiter #(.X(3), .Y(1), .Z(1), .CORES_PER_TILE(3)) dut_b (
        .cpu_clk_i(clk), .cpu_rst_i(rst),
        .req_stb_i(b_req_stb), .req_we_i(b_req_we), .req_core_i(b_req_core),
        .req_addr_i(b_req_addr), .req_data_i(b_req_data),
        .req_ack_o(b_req_ack), .req_err_o(b_req_err), .req_data_o(b_req_rdata),
        .cpu_stb_o(b_cpu_stb), .cpu_we_o(b_cpu_we), .cpu_addr_o(b_cpu_addr), .cpu_data_o(b_cpu_wdata),
        .cpu_data_i(b_cpu_rdata), .cpu_ack_i(b_cpu_ack)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stb"}, cpu_stb, 0);
        chk({tag, "_we"}, cpu_we, 0);
        chk({tag, "_addr"}, cpu_addr, 0);
        chk({tag, "_wdata"}, cpu_wdata, 0);
        chk({tag, "_ack"}, req_ack, 0);
        chk({tag, "_err"}, req_err, 0);
        chk({tag, "_rdata"}, req_rdata, 0);
    endtask

    task automatic set_req(input int r, input int core, input bit we, input logic [31:0] addr, input logic [31:0] data);
        req_stb[r] = 1'b1;
        req_we[r] = we;
        req_core[r*5 +: 5] = core[4:0];
        req_addr[r*32 +: 32] = addr;
        req_data[r*32 +: 32] = data;
        m_core[r] = core;
        m_we[r] = we;
        m_addr[r] = addr;
        m_data[r] = data;
    endtask

    task automatic rand_req(input int r);
        set_req(r, $urandom_range(0, 31), 1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    // Runs one access from IDLE to the following IDLE; ack_at is the BUSY cycle in which the core acks (>255 = never)
    task automatic run_access(input int ack_at, input logic [31:0] rd, input bit drop_early);
        int g, cyc, nstb, exp_stb, c;
        bit done, to;
        g = req_stb[(tb_last + 1) % 2] ? (tb_last + 1) % 2 : tb_last;
        c = m_core[g];
        to = ack_at > 255;
        exp_stb = to ? 256 : ack_at + 1;
        for (int k = 0; k < 32; k++) cpu_rdata[k*32 +: 32] = $urandom;
        cyc = 0;
        nstb = 0;
        done = 0;
        while (!done && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            cpu_ack = '0;
            chk("onehot", 64'($countones(cpu_stb) <= 1), 1);
            if (cpu_stb != 0) begin
                chk("stb", cpu_stb, 32'd1 << c);
                chk("we", cpu_we, m_we[g] ? 32'd1 << c : 32'd0);
                chk("addr", cpu_addr, m_addr[g]);
                chk("wdata", cpu_wdata, m_data[g]);
                if (nstb == 0) begin
                    req_addr[g*32 +: 32] = $urandom;
                    req_data[g*32 +: 32] = $urandom;
                    req_core[g*5 +: 5] = 5'($urandom);
                    req_we[g] = ~req_we[g];
                    if (drop_early) req_stb[g] = 1'b0;
                end
                cpu_ack = $urandom & ~(32'd1 << c);
                cpu_rdata[c*32 +: 32] = (nstb == ack_at) ? rd : $urandom;
                if (nstb == ack_at) cpu_ack[c] = 1'b1;
                nstb++;
            end
            if (req_ack != 0) begin
                chk("grant", req_ack, 2'd1 << g);
                chk("err", req_err, to);
                chk("rdata", req_rdata, to ? 32'd0 : rd);
                chk("stb_cycles", nstb, exp_stb);
                chk("latency", cyc, exp_stb + 1);
                req_stb[g] = 1'b0;
                tb_last = g;
                done = 1;
            end
        end
        if (!done) chk("ack_bound", 0, 1);
        cpu_ack = '0;
        @(posedge clk);
        #1;
        chk("pulse_len", req_ack, 0);
        chk("idle_stb", cpu_stb, 0);
    endtask

    initial begin
        rst = 1'b1;
        req_stb = '0; req_we = '0; req_core = '0; req_addr = '0; req_data = '0;
        cpu_ack = '0; cpu_rdata = '0;
        b_req_stb = '0; b_req_we = '0; b_req_core = '0; b_req_addr = '0; b_req_data = '0;
        b_cpu_ack = '0; b_cpu_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        tb_last = 1;

        set_req(0, 5, 1'b0, 32'h100, $urandom);
        run_access(0, 32'hDEADBEEF, 0);

        for (int k = 0; k < 6; k++) begin
            for (int r = 0; r < 2; r++) if (!req_stb[r]) rand_req(r);
            run_access($urandom_range(0, 3), $urandom, 0);
        end
        run_access(2, $urandom, 0);

        set_req(1, 31, 1'b1, $urandom, 32'h12345678);
        run_access(1000, 32'h0, 0);

        set_req(0, 9, 1'b0, $urandom, $urandom);
        run_access(255, 32'hCAFEF00D, 0);

        set_req(1, 17, 1'b0, $urandom, $urandom);
        run_access(1, 32'h5A5A1234, 1);

        for (int k = 0; k < 16; k++) begin
            for (int r = 0; r < 2; r++) if (!req_stb[r] && $urandom_range(0, 1) == 1) rand_req(r);
            if (req_stb == 0) rand_req($urandom_range(0, 1));
            run_access(($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 255 : 300) : $urandom_range(0, 6),
                       $urandom, 1'($urandom_range(0, 3) == 0));
        end
        while (req_stb != 0) run_access(0, $urandom, 0);

        set_req(1, 7, 1'b1, $urandom, $urandom);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("pre_rst_stb", cpu_stb, 32'd1 << 7);
        end
        @(posedge clk);
        #1;
        chk("busy3_stb", cpu_stb, 32'd1 << 7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("busy_reset");
        rst = 1'b0;
        tb_last = 1;
        set_req(0, 3, 1'b0, $urandom, $urandom);
        run_access(0, 32'h0BADF00D, 0);
        run_access(1, 32'h600DCAFE, 0);

        b_req_stb = 2'b01;
        b_req_core = 8'h0C;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("b_stb", b_cpu_stb, 0);
            chk("b_ack", b_req_ack, k == 0 ? 2'b01 : 2'b00);
            chk("b_err", b_req_err, k == 0);
            chk("b_rdata", b_req_rdata, 0);
            b_req_stb = 2'b00;
        end
        b_req_stb = 2'b10;
        b_req_we = 2'b10;
        b_req_core = 8'h80;
        b_req_addr = {32'hA5, 32'h0};
        @(posedge clk);
        #1;
        chk("b_valid_stb", b_cpu_stb, 9'h100);
        chk("b_valid_we", b_cpu_we, 9'h100);
        chk("b_valid_addr", b_cpu_addr, 32'hA5);
        b_cpu_ack = 9'h100;
        b_cpu_rdata[8*32 +: 32] = 32'h13579BDF;
        @(posedge clk);
        #1;
        b_cpu_ack = '0;
        chk("b_valid_ack", b_req_ack, 2'b10);
        chk("b_valid_err", b_req_err, 0);
        chk("b_valid_rdata", b_req_rdata, 32'h13579BDF);
        b_req_stb = '0;
        @(posedge clk);
        #1;
        chk("b_valid_idle", b_req_ack, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
